// File: rtl/sr04_emulator.sv
// HC-SR04 sensor-side emulator: validates the trigger pulse, waits the burst time, then
// answers with an echo pulse proportional to i_range_cm, followed by a holdoff.
module sr04_emulator #(
  parameter int RANGE_WIDTH      = 16,
  parameter int DELAY_CLK_1US    = 50,
  parameter int DELAY_1US_1SM    = 58,
  parameter int DELAY_TRIGGER_US = 10,
  parameter int DELAY_BURST_US   = 200,
  parameter int DELAY_NOECHO_US  = 38000,
  parameter int RANGE_MAX_CM     = 400,
  parameter int DELAY_HOLDOFF_US = 1000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_trigger,
  input  logic [RANGE_WIDTH-1:0] i_range_cm,
  output logic                   o_echo,
  output logic                   o_busy,
  output logic                   o_meas_done
);

  localparam int MAX_AB  = (DELAY_NOECHO_US > DELAY_HOLDOFF_US) ? DELAY_NOECHO_US : DELAY_HOLDOFF_US;
  localparam int MAX_ABC = (MAX_AB > DELAY_BURST_US) ? MAX_AB : DELAY_BURST_US;
  localparam int CNT_MAX = (MAX_ABC > DELAY_TRIGGER_US) ? MAX_ABC : DELAY_TRIGGER_US;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DIV_W   = $clog2(DELAY_CLK_1US + 1);
  localparam int SM_W    = $clog2(DELAY_1US_1SM + 1);

  localparam logic [DIV_W-1:0]       DIV_LAST    = DIV_W'(DELAY_CLK_1US - 1);
  localparam logic [SM_W-1:0]        SM_LAST     = SM_W'(DELAY_1US_1SM - 1);
  localparam logic [CNT_W-1:0]       TRIG_MIN    = CNT_W'(DELAY_TRIGGER_US);
  localparam logic [CNT_W-1:0]       BURST_LAST  = CNT_W'(DELAY_BURST_US - 1);
  localparam logic [CNT_W-1:0]       NOECHO_LAST = CNT_W'(DELAY_NOECHO_US - 1);
  localparam logic [CNT_W-1:0]       HOLD_LAST   = CNT_W'(DELAY_HOLDOFF_US - 1);
  localparam logic [RANGE_WIDTH-1:0] RANGE_MAX   = RANGE_WIDTH'(RANGE_MAX_CM);

  // state   | meaning
  // IDLE    | waiting for a fresh trigger rising edge
  // TRIG    | trigger high, measuring its width
  // BURST   | emulated ultrasonic burst, echo low
  // ECHO    | echo high for the emulated time of flight
  // HOLDOFF | dead time, triggers ignored
  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_BURST, S_ECHO, S_HOLDOFF} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_sync1;
  logic                   r_trig_s;
  logic                   r_trig_d;
  logic [DIV_W-1:0]       r_div;
  logic [CNT_W-1:0]       r_us_cnt;
  logic [SM_W-1:0]        r_sm_cnt;
  logic [RANGE_WIDTH-1:0] r_cm_cnt;
  logic [RANGE_WIDTH-1:0] r_rng_q;
  logic                   r_echo;
  logic                   r_busy;
  logic                   r_done;
  logic                   w_us_tick;
  logic                   w_state_chg;
  logic                   w_noecho;
  logic                   w_echo_nxt;
  logic                   w_busy_nxt;
  logic                   w_done;
  logic                   w_us_run;

  // Synchronizer resets high so a trigger held through reset release is not seen as an edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1  <= 1'b1;
      r_trig_s <= 1'b1;
      r_trig_d <= 1'b1;
    end else begin
      r_sync1  <= i_trigger;
      r_trig_s <= r_sync1;
      r_trig_d <= r_trig_s;
    end
  end

  assign w_us_tick   = (r_div == DIV_LAST);
  assign w_state_chg = (w_state_nxt != r_state);
  assign w_noecho    = (r_rng_q == '0) || (r_rng_q > RANGE_MAX);
  assign w_us_run    = (r_state != S_IDLE) && !((r_state == S_TRIG) && (r_us_cnt >= TRIG_MIN));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div    <= '0;
      r_us_cnt <= '0;
      r_sm_cnt <= '0;
      r_cm_cnt <= '0;
    end else if (w_state_chg) begin
      r_div    <= '0;
      r_us_cnt <= '0;
      r_sm_cnt <= '0;
      r_cm_cnt <= '0;
    end else begin
      r_div <= w_us_tick ? '0 : r_div + 1'b1;
      if (w_us_tick) begin
        if (w_us_run) r_us_cnt <= r_us_cnt + 1'b1;
        if (r_state == S_ECHO) begin
          if (r_sm_cnt == SM_LAST) begin
            r_sm_cnt <= '0;
            r_cm_cnt <= r_cm_cnt + 1'b1;
          end else begin
            r_sm_cnt <= r_sm_cnt + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rng_q <= '0;
    end else if ((r_state == S_TRIG) && (w_state_nxt == S_BURST)) begin
      r_rng_q <= i_range_cm;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_trig_s && !r_trig_d) w_state_nxt = S_TRIG;
      end
      S_TRIG: begin
        if (!r_trig_s) w_state_nxt = (r_us_cnt >= TRIG_MIN) ? S_BURST : S_IDLE;
      end
      S_BURST: begin
        if (w_us_tick && (r_us_cnt == BURST_LAST)) w_state_nxt = S_ECHO;
      end
      S_ECHO: begin
        if (w_us_tick && (w_noecho ? (r_us_cnt == NOECHO_LAST)
                                   : ((r_sm_cnt == SM_LAST) && (r_cm_cnt == r_rng_q - 1'b1)))) begin
          w_state_nxt = S_HOLDOFF;
          w_done      = 1'b1;
        end
      end
      S_HOLDOFF: begin
        if (w_us_tick && (r_us_cnt == HOLD_LAST)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_echo_nxt = (w_state_nxt == S_ECHO);
  assign w_busy_nxt = (w_state_nxt == S_BURST) || (w_state_nxt == S_ECHO) || (w_state_nxt == S_HOLDOFF);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_echo  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_echo  <= w_echo_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done;
    end
  end

  assign o_echo      = r_echo;
  assign o_busy      = r_busy;
  assign o_meas_done = r_done;

endmodule

// File: tb/tb_sr04_emulator.sv
// Self-checking bench for sr04_emulator: directed cases plus randomized trigger widths and
// ranges, compared against pulse timings computed from the protocol rules.
module tb_sr04_emulator;

  localparam int CLK_1US   = 2;
  localparam int US_SM     = 3;
  localparam int TRIG_US   = 10;
  localparam int BURST_US  = 4;
  localparam int NOECHO_US = 50;
  localparam int RMAX      = 10;
  localparam int HOLD_US   = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trigger = 1'b0;
  logic [15:0] range_cm = '0;
  logic        echo;
  logic        busy;
  logic        meas_done;

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0;
  int n_rise = 0, rise_c = 0, fall_c = 0;
  int n_brise = 0, brise_c = 0, bfall_c = 0;
  int n_md = 0, md_c = 0;
  logic p_echo = 1'b0, p_busy = 1'b0;

  sr04_emulator #(
    .RANGE_WIDTH     (16),
    .DELAY_CLK_1US   (CLK_1US),
    .DELAY_1US_1SM   (US_SM),
    .DELAY_TRIGGER_US(TRIG_US),
    .DELAY_BURST_US  (BURST_US),
    .DELAY_NOECHO_US (NOECHO_US),
    .RANGE_MAX_CM    (RMAX),
    .DELAY_HOLDOFF_US(HOLD_US)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_trigger  (trigger),
    .i_range_cm (range_cm),
    .o_echo     (echo),
    .o_busy     (busy),
    .o_meas_done(meas_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Edge log of the outputs, sampled mid-cycle; cyc names the edge that caused the change.
  always @(negedge clk) begin
    if (echo && !p_echo) begin n_rise++; rise_c = cyc; end
    if (!echo && p_echo) fall_c = cyc;
    if (busy && !p_busy) begin n_brise++; brise_c = cyc; end
    if (!busy && p_busy) bfall_c = cyc;
    if (meas_done) begin n_md++; md_c = cyc; end
    p_echo = echo;
    p_busy = busy;
  end

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int exp_echo_clk(input int rng);
    if (rng == 0 || rng > RMAX) return NOECHO_US * CLK_1US;
    return rng * US_SM * CLK_1US;
  endfunction

  // width: trigger high time in clk; new_rng >= 0 changes range mid-echo; glitch adds
  // trigger pulses in BURST/ECHO/HOLDOFF; rst_at > 0 pulses reset at that cycle after trigger fall.
  task automatic run_meas(input int width, input int rng, input int new_rng,
                          input bit glitch, input int rst_at);
    int  r0, b0, m0, t_fall, w_exp, e1, busy_w, win;
    bit  acc;
    acc    = (width >= (TRIG_US + 1) * CLK_1US);
    w_exp  = exp_echo_clk(rng);
    e1     = 3 + BURST_US * CLK_1US;
    busy_w = BURST_US * CLK_1US + w_exp + HOLD_US * CLK_1US;
    win    = acc ? (3 + busy_w + 30) : 40;
    r0 = n_rise; b0 = n_brise; m0 = n_md;
    @(posedge clk); #1;
    trigger  = 1'b1;
    range_cm = 16'(rng);
    repeat (width) @(posedge clk);
    #1 trigger = 1'b0;
    t_fall = cyc;
    for (int i = 1; i <= win; i++) begin
      @(posedge clk); #1;
      if (glitch) trigger = (i >= 4 && i < 8) || (i >= 14 && i < 36) || (i >= 44 && i < 60);
      if (new_rng >= 0 && i == e1 + 5) range_cm = 16'(new_rng);
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("async_rst_echo", echo, 0);
        check("async_rst_busy", busy, 0);
      end
      if (rst_at > 0 && i == rst_at + 3) rst_n = 1'b1;
    end
    if (rst_at > 0) begin
      check("rst_echo_rises", n_rise - r0, 1);
      check("rst_no_done", n_md - m0, 0);
    end else if (!acc) begin
      check("rej_echo_rises", n_rise - r0, 0);
      check("rej_busy_rises", n_brise - b0, 0);
    end else begin
      check("echo_rises", n_rise - r0, 1);
      check("echo_rise_lat", rise_c - t_fall, e1);
      check("echo_width", fall_c - rise_c, w_exp);
      check("done_pulses", n_md - m0, 1);
      check("done_at_fall", md_c - fall_c, 0);
      check("busy_rises", n_brise - b0, 1);
      check("busy_rise_lat", brise_c - t_fall, 3);
      check("busy_width", bfall_c - brise_c, busy_w);
    end
  endtask

  initial begin
    int w, r, nr;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_echo", echo, 0);
    check("reset_busy", busy, 0);
    check("reset_done", meas_done, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    run_meas(24, 5, -1, 1'b0, -1);
    run_meas(18, 5, -1, 1'b0, -1);
    run_meas(24, 7, -1, 1'b0, -1);
    run_meas(22, 3, -1, 1'b0, -1);
    run_meas(24, 0, -1, 1'b0, -1);
    run_meas(24, 11, -1, 1'b0, -1);
    run_meas(24, 10, -1, 1'b0, -1);
    run_meas(24, 5, -1, 1'b1, -1);
    run_meas(24, 5, -1, 1'b0, -1);
    run_meas(24, 5, 9, 1'b0, -1);
    run_meas(24, 5, -1, 1'b0, 21);
    run_meas(24, 5, -1, 1'b0, -1);

    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 1) == 1) w = int'($urandom_range(22, 34));
      else                           w = int'($urandom_range(1, 18));
      r  = int'($urandom_range(0, 13));
      nr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 13)) : -1;
      run_meas(w, r, nr, 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
